// File: rtl/sha3_pkg.sv
// Shared SHA3-512 core constants and the digest squeezer state type.
// Lane 0 of the permutation state occupies the most significant 64 bits.
package sha3_pkg;

  localparam int STATE_W  = 1600;
  localparam int RATE_W   = 576;
  localparam int DIGEST_W = 512;
  localparam int LANE_W   = 64;

  typedef enum logic [1:0] {
    SQ_IDLE = 2'd0,
    SQ_WAIT = 2'd1,
    SQ_EMIT = 2'd2
  } sq_state_t;

endpackage

// File: rtl/sha3_word_mux.sv
// Selects one digest word from the snapshot by word index.
// Word 0 is the most significant word of the snapshot.
module sha3_word_mux #(
  parameter int WORD_W    = 64,
  parameter int OUT_WORDS = 8,
  parameter int IDX_W     = 3
) (
  input  logic [OUT_WORDS*WORD_W-1:0] snap_i,
  input  logic [IDX_W-1:0]            idx_i,
  output logic [WORD_W-1:0]           word_o
);

  always_comb begin
    word_o = '0;
    for (int i = 0; i < OUT_WORDS; i++) begin
      if (idx_i == IDX_W'(i)) begin
        word_o = snap_i[(OUT_WORDS-i)*WORD_W-1 -: WORD_W];
      end
    end
  end

endmodule

// File: rtl/sha3_digest_squeezer.sv
// Captures the final permutation state and streams the digest
// as OUT_WORDS words over a valid/ready interface.
module sha3_digest_squeezer
  import sha3_pkg::*;
#(
  parameter int WORD_W    = LANE_W,
  parameter int OUT_WORDS = DIGEST_W / LANE_W,
  parameter int STATE_W   = sha3_pkg::STATE_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               perm_ack,
  input  logic               perm_last,
  input  logic [STATE_W-1:0] state_in,
  input  logic               state_ready,
  output logic [WORD_W-1:0]  dout,
  output logic               dout_valid,
  input  logic               dout_ready,
  output logic               dout_last,
  output logic               busy,
  output logic               err
);

  localparam int SNAP_W = OUT_WORDS * WORD_W;
  localparam int IDX_W  = $clog2(OUT_WORDS);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(OUT_WORDS - 1);

  sq_state_t          state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [SNAP_W-1:0]  snap_q, snap_d;
  logic [WORD_W-1:0]  dout_q, dout_d, word_d;
  logic               valid_q, valid_d;
  logic               err_q, err_d;
  logic               xfer, arm;

  logic unused_state;
  assign unused_state = ^state_in[STATE_W-SNAP_W-1:0];

  assign xfer = valid_q & dout_ready;
  assign arm  = perm_ack & perm_last;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    snap_d  = snap_q;
    valid_d = valid_q;
    err_d   = err_q;
    unique case (state_q)
      SQ_IDLE: if (arm) state_d = SQ_WAIT;
      SQ_WAIT: begin
        if (state_ready) begin
          state_d = SQ_EMIT;
          snap_d  = state_in[STATE_W-1 -: SNAP_W];
          idx_d   = '0;
          valid_d = 1'b1;
        end
      end
      SQ_EMIT: begin
        // a new arm while draining is dropped, only flagged
        if (arm) err_d = 1'b1;
        if (xfer) begin
          if (idx_q == LAST) begin
            state_d = SQ_IDLE;
            idx_d   = '0;
            valid_d = 1'b0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = SQ_IDLE;
    endcase
  end

  sha3_word_mux #(
    .WORD_W   (WORD_W),
    .OUT_WORDS(OUT_WORDS),
    .IDX_W    (IDX_W)
  ) u_mux (
    .snap_i(snap_d),
    .idx_i (idx_d),
    .word_o(word_d)
  );

  assign dout_d = valid_d ? word_d : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SQ_IDLE;
      idx_q   <= '0;
      snap_q  <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = valid_q;
  assign dout_last  = valid_q & (idx_q == LAST);
  assign busy       = (state_q != SQ_IDLE);
  assign err        = err_q;

endmodule

// File: tb/tb_sha3_digest_squeezer.sv
// Bench for sha3_digest_squeezer: queue-based digest model plus
// directed literal checks and a randomized soak.
module tb_sha3_digest_squeezer;

  logic          clk = 1'b0;
  logic          reset;
  logic          perm_ack, perm_last, state_ready, dout_ready;
  logic [1599:0] state_in;
  logic [63:0]   dout;
  logic          dout_valid, dout_last, busy, err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sha3_digest_squeezer dut (
    .clk        (clk),
    .reset      (reset),
    .perm_ack   (perm_ack),
    .perm_last  (perm_last),
    .state_in   (state_in),
    .state_ready(state_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout_last  (dout_last),
    .busy       (busy),
    .err        (err)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: pending digest words, armed flag, sticky error.
  logic [63:0] exp_q[$];
  bit m_armed = 0, m_err = 0, m_live = 0, m_rst = 0;

  always @(posedge clk) begin
    if (reset) begin
      exp_q.delete();
      m_armed = 0;
      m_err   = 0;
      m_live  = 1;
      m_rst   = 1;
    end else begin
      m_rst = 0;
      if (exp_q.size() > 0) begin
        if (perm_ack && perm_last) m_err = 1;
        if (dout_ready) void'(exp_q.pop_front());
      end else if (m_armed) begin
        if (state_ready) begin
          for (int k = 0; k < 8; k++)
            exp_q.push_back(state_in[1599-64*k -: 64]);
          m_armed = 0;
        end
      end else if (perm_ack && perm_last) begin
        m_armed = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      chk("valid", 64'(dout_valid), 64'(exp_q.size() > 0));
      chk("busy", 64'(busy), 64'(m_armed || exp_q.size() > 0));
      chk("err", 64'(err), 64'(m_err));
      chk("last", 64'(dout_last), 64'(exp_q.size() == 1));
      if (exp_q.size() > 0) chk("dout", dout, exp_q[0]);
      if (m_rst) chk("dout_rst", dout, 64'd0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_state(output logic [1599:0] s);
    for (int i = 0; i < 50; i++) s[32*i +: 32] = $urandom;
  endtask

  function automatic logic [63:0] lane_lit(input int k);
    logic [3:0] n;
    n = k[3:0];
    return (k == 0) ? 64'h0123456789ABCDEF : {16{n}};
  endfunction

  task automatic dir_state(output logic [1599:0] s);
    rand_state(s);
    for (int k = 0; k < 8; k++) s[1599-64*k -: 64] = lane_lit(k);
  endtask

  task automatic start_msg(input logic [1599:0] s, input int gap);
    perm_ack  = 1;
    perm_last = 1;
    step();
    perm_ack  = 0;
    perm_last = 0;
    repeat (gap) step();
    state_in    = s;
    state_ready = 1;
    step();
    state_ready = 0;
  endtask

  task automatic drain(input logic [1599:0] s, input string nm);
    dout_ready = 1;
    for (int k = 0; k < 8; k++) begin
      chk({nm, "_v"}, 64'(dout_valid), 64'd1);
      chk({nm, "_w"}, dout, s[1599-64*k -: 64]);
      chk({nm, "_l"}, 64'(dout_last), 64'(k == 7));
      step();
    end
    chk({nm, "_busy"}, 64'(busy), 64'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1599:0] s;
    int n, cyc;
    logic [63:0] prev;
    bit stalled;

    reset       = 1;
    perm_ack    = 1'($urandom);
    perm_last   = 1'($urandom);
    state_ready = 1'($urandom);
    dout_ready  = 1'($urandom);
    rand_state(state_in);
    repeat (2) step();
    chk("rst_valid", 64'(dout_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_dout", dout, 64'd0);
    reset = 0;
    perm_ack = 0; perm_last = 0; state_ready = 0; dout_ready = 1;
    step();

    // single message, literal lanes
    dir_state(s);
    start_msg(s, 24);
    for (int k = 0; k < 8; k++) begin
      chk("lit_w", dout, lane_lit(k));
      chk("lit_l", 64'(dout_last), 64'(k == 7));
      step();
    end
    chk("lit_busy", 64'(busy), 64'd0);
    chk("lit_valid", 64'(dout_valid), 64'd0);
    step();

    // backpressure 1,0,0,...
    start_msg(s, 24);
    n = 0; cyc = 0; stalled = 0; prev = '0;
    while (n < 8 && cyc < 60) begin
      dout_ready = (cyc % 3 == 0);
      if (stalled) chk("bp_hold", dout, prev);
      if (dout_valid && dout_ready) begin
        chk("bp_w", dout, lane_lit(n));
        n++;
      end
      stalled = dout_valid && !dout_ready;
      prev = dout;
      step();
      cyc++;
    end
    chk("bp_count", 64'(n), 64'd8);
    chk("bp_busy", 64'(busy), 64'd0);
    dout_ready = 1;
    step();

    // non-last blocks are ignored
    for (int b = 0; b < 3; b++) begin
      perm_ack = 1; perm_last = 0;
      rand_state(state_in);
      step();
      perm_ack = 0;
      repeat (3) step();
      state_ready = 1;
      step();
      state_ready = 0;
      step();
      chk("nl_busy", 64'(busy), 64'd0);
      chk("nl_valid", 64'(dout_valid), 64'd0);
    end
    rand_state(s);
    start_msg(s, 5);
    drain(s, "nl4");
    step();

    // violation during word 3
    rand_state(s);
    start_msg(s, 4);
    repeat (3) step();
    chk("vi_w3", dout, s[1599-64*3 -: 64]);
    perm_ack = 1; perm_last = 1;
    step();
    perm_ack = 0; perm_last = 0;
    chk("vi_err", 64'(err), 64'd1);
    repeat (4) step();
    chk("vi_busy", 64'(busy), 64'd0);
    repeat (5) step();
    chk("vi_sticky", 64'(err), 64'd1);

    // reset mid-EMIT after two transfers
    rand_state(s);
    start_msg(s, 3);
    repeat (2) step();
    reset = 1;
    step();
    reset = 0;
    chk("mr_valid", 64'(dout_valid), 64'd0);
    chk("mr_busy", 64'(busy), 64'd0);
    chk("mr_err", 64'(err), 64'd0);
    step();
    rand_state(s);
    start_msg(s, 6);
    drain(s, "mr");

    // randomized soak against the model
    for (int i = 0; i < 3000; i++) begin
      reset       = ($urandom % 500 == 0);
      perm_ack    = ($urandom % 8 == 0);
      perm_last   = 1'($urandom);
      state_ready = ($urandom % 5 == 0);
      dout_ready  = ($urandom % 4 != 0);
      if ($urandom % 4 == 0) rand_state(state_in);
      step();
    end
    reset = 0; perm_ack = 0; perm_last = 0;
    state_ready = 0; dout_ready = 1;
    repeat (20) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
